// File: rtl/ag32gbd_pkg.sv
// Shared definitions for the camera double-buffer reader and its controller.
package ag32gbd_pkg;

    // Byte offset width on the buffer-read request interface.
    localparam int OFFSET_W  = 10;
    // Bytes per capture buffer; the controller places its buffer bases on this.
    localparam int BUF_BYTES = 256;
    // Byte counter width: must be able to represent BUF_BYTES itself.
    localparam int CNT_W     = 9;
    // Shared request-hold / timeout down-counter width.
    localparam int TMR_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LO,
        WAIT_HI,
        OUT,
        FLIP,
        FIN
    } state_t;

endpackage

// File: rtl/ag32gbd_buffer_reader_if.sv
// Buffer-read request bus toward the BRAM controller plus the byte stream
// toward the host bridge. master = reader side, slave = controller/sink side.
interface ag32gbd_buffer_reader_if;
    import ag32gbd_pkg::*;

    logic                req_read_buffer;
    logic [OFFSET_W-1:0] read_offset;
    logic [7:0]          read_data;
    logic                read_data_ready;
    logic                flip_buffer;
    logic [7:0]          pix_data;
    logic                pix_valid;
    logic                pix_last;
    logic                pix_ready;

    modport master (
        output req_read_buffer, read_offset, flip_buffer,
        output pix_data, pix_valid, pix_last,
        input  read_data, read_data_ready, pix_ready
    );

    modport slave (
        input  req_read_buffer, read_offset, flip_buffer,
        input  pix_data, pix_valid, pix_last,
        output read_data, read_data_ready, pix_ready
    );

endinterface

// File: rtl/ag32gbd_buffer_reader.sv
// Sequential frame reader: fetches FRAME_BYTES bytes one at a time from the
// controller's read buffer, streams them out, then optionally flips buffers.
import ag32gbd_pkg::*;

module ag32gbd_buffer_reader #(
    parameter int FRAME_BYTES = 256,
    parameter int REQ_HOLD    = 4,
    parameter int TIMEOUT     = 31
) (
    input  logic                     sys_clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     flip_on_done,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    ag32gbd_buffer_reader_if.master  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(REQ_HOLD - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                req_q, req_d;
    logic                fod_q, fod_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                flip_q, flip_d;
    logic [7:0]          pdata_q, pdata_d;
    logic                pvalid_q, pvalid_d;
    logic                plast_q, plast_d;

    // Next-state and registered-output logic for the readout sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        offset_d = offset_q;
        req_d    = req_q;
        fod_d    = fod_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        flip_d   = flip_q;
        pdata_d  = pdata_q;
        pvalid_d = pvalid_q;
        plast_d  = plast_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fod_d    = flip_on_done;
                    cnt_d    = '0;
                    offset_d = '0;
                    busy_d   = 1'b1;
                    req_d    = 1'b1;
                    tmr_d    = HOLD_LOAD;
                    state_d  = REQ;
                end
            end

            // Request held long enough for the controller's synchroniser.
            REQ: begin
                if (tmr_q == '0) begin
                    req_d   = 1'b0;
                    tmr_d   = TMO_LOAD;
                    state_d = WAIT_LO;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            // Ready already low on entry counts as accepted.
            WAIT_LO: begin
                if (!bus.read_data_ready) begin
                    state_d = WAIT_HI;
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end else if (tmr_q == '0) begin
                    error_d  = 1'b1;
                    busy_d   = 1'b0;
                    pvalid_d = 1'b0;
                    plast_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            WAIT_HI: begin
                if (bus.read_data_ready) begin
                    pdata_d  = bus.read_data;
                    pvalid_d = 1'b1;
                    plast_d  = (cnt_q == LAST_IDX);
                    state_d  = OUT;
                end else if (tmr_q == '0) begin
                    error_d  = 1'b1;
                    busy_d   = 1'b0;
                    pvalid_d = 1'b0;
                    plast_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end

            // Holds the byte until downstream takes it; no timeout here.
            OUT: begin
                if (bus.pix_ready) begin
                    pvalid_d = 1'b0;
                    plast_d  = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = fod_q ? FLIP : FIN;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        offset_d = OFFSET_W'(cnt_q + 1'b1);
                        req_d    = 1'b1;
                        tmr_d    = HOLD_LOAD;
                        state_d  = REQ;
                    end
                end
            end

            FLIP: begin
                flip_d  = ~flip_q;
                state_d = FIN;
            end

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            offset_q <= '0;
            req_q    <= 1'b0;
            fod_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            flip_q   <= 1'b0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
            plast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            offset_q <= offset_d;
            req_q    <= req_d;
            fod_q    <= fod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            flip_q   <= flip_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            plast_q  <= plast_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign bus.req_read_buffer = req_q;
    assign bus.read_offset     = offset_q;
    assign bus.flip_buffer     = flip_q;
    assign bus.pix_data        = pdata_q;
    assign bus.pix_valid       = pvalid_q;
    assign bus.pix_last        = plast_q;

endmodule

// File: tb/tb_ag32gbd_buffer_reader.sv
// Directed bench: a 4-byte-frame reader and a 256-byte-frame reader, each
// against a controller model (3-cycle request synchroniser, 1-cycle read)
// that returns 0xA0+offset.
module tb_ag32gbd_buffer_reader;

    logic sys_clock = 1'b0;
    logic resetn;
    logic start_a, fod_a, busy_a, done_a, error_a;
    logic start_b, fod_b, busy_b, done_b, error_b;
    bit   hang_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clock = ~sys_clock;

    ag32gbd_buffer_reader_if bus_a ();
    ag32gbd_buffer_reader_if bus_b ();

    ag32gbd_buffer_reader #(.FRAME_BYTES(4), .REQ_HOLD(4), .TIMEOUT(31)) dut_a (
        .sys_clock(sys_clock), .resetn(resetn), .start(start_a), .flip_on_done(fod_a),
        .busy(busy_a), .done(done_a), .error(error_a), .bus(bus_a)
    );

    ag32gbd_buffer_reader #(.FRAME_BYTES(256), .REQ_HOLD(4), .TIMEOUT(31)) dut_b (
        .sys_clock(sys_clock), .resetn(resetn), .start(start_b), .flip_on_done(fod_b),
        .busy(busy_b), .done(done_b), .error(error_b), .bus(bus_b)
    );

    // Controller model A (can be told never to accept a request).
    logic [2:0] sync_a;
    logic       prev_a, pend_a;
    always @(posedge sys_clock) begin
        if (!resetn) begin
            sync_a <= '0; prev_a <= 1'b0; pend_a <= 1'b0;
            bus_a.read_data_ready <= 1'b1; bus_a.read_data <= 8'h00;
        end else begin
            sync_a <= {sync_a[1:0], bus_a.req_read_buffer};
            prev_a <= sync_a[2];
            if (pend_a) begin
                bus_a.read_data       <= 8'hA0 + bus_a.read_offset[7:0];
                bus_a.read_data_ready <= 1'b1;
                pend_a                <= 1'b0;
            end else if (sync_a[2] && !prev_a && !hang_a) begin
                bus_a.read_data_ready <= 1'b0;
                pend_a                <= 1'b1;
            end
        end
    end

    // Controller model B.
    logic [2:0] sync_b;
    logic       prev_b, pend_b;
    always @(posedge sys_clock) begin
        if (!resetn) begin
            sync_b <= '0; prev_b <= 1'b0; pend_b <= 1'b0;
            bus_b.read_data_ready <= 1'b1; bus_b.read_data <= 8'h00;
        end else begin
            sync_b <= {sync_b[1:0], bus_b.req_read_buffer};
            prev_b <= sync_b[2];
            if (pend_b) begin
                bus_b.read_data       <= 8'hA0 + bus_b.read_offset[7:0];
                bus_b.read_data_ready <= 1'b1;
                pend_b                <= 1'b0;
            end else if (sync_b[2] && !prev_b) begin
                bus_b.read_data_ready <= 1'b0;
                pend_b                <= 1'b1;
            end
        end
    end

    // Stream / request monitors, sampled on the falling edge.
    logic [8:0] qdata_a[$];
    logic [9:0] qoff_a[$];
    logic [8:0] qdata_b[$];
    logic [9:0] qoff_b[$];
    logic       rprev_a = 1'b0, rprev_b = 1'b0;
    int         dones_a = 0, errs_a = 0, flips_a = 0;
    logic       fprev_a = 1'b0;
    always @(negedge sys_clock) begin
        if (bus_a.pix_valid && bus_a.pix_ready) qdata_a.push_back({bus_a.pix_last, bus_a.pix_data});
        if (bus_a.req_read_buffer && !rprev_a) qoff_a.push_back(bus_a.read_offset);
        if (bus_b.pix_valid && bus_b.pix_ready) qdata_b.push_back({bus_b.pix_last, bus_b.pix_data});
        if (bus_b.req_read_buffer && !rprev_b) qoff_b.push_back(bus_b.read_offset);
        rprev_a <= bus_a.req_read_buffer;
        rprev_b <= bus_b.req_read_buffer;
        if (done_a)  dones_a <= dones_a + 1;
        if (error_a) errs_a  <= errs_a + 1;
        if (bus_a.flip_buffer !== fprev_a) flips_a <= flips_a + 1;
        fprev_a <= bus_a.flip_buffer;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic pulse_start_a(input logic fod);
        fod_a = fod; start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step();
            if (done_a || error_a) break;
        end
        chk({tag, "_done"}, {31'd0, done_a}, 32'd1);
        repeat (2) step();
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
        chk({tag, "_error"}, {31'd0, error_a}, 32'd0);
        chk({tag, "_req"}, {31'd0, bus_a.req_read_buffer}, 32'd0);
        chk({tag, "_offset"}, {22'd0, bus_a.read_offset}, 32'd0);
        chk({tag, "_flip"}, {31'd0, bus_a.flip_buffer}, 32'd0);
        chk({tag, "_pvalid"}, {31'd0, bus_a.pix_valid}, 32'd0);
        chk({tag, "_plast"}, {31'd0, bus_a.pix_last}, 32'd0);
        chk({tag, "_pdata"}, {24'd0, bus_a.pix_data}, 32'd0);
    endtask

    // Four bytes A0..A3 in order, last only on A3, offsets 0..3.
    task automatic chk_frame_a(input string tag);
        chk({tag, "_nbytes"}, qdata_a.size(), 32'd4);
        chk({tag, "_nreqs"}, qoff_a.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {23'd0, qdata_a[i]},
                {23'd0, (i == 3), 8'(8'hA0 + i)});
            chk($sformatf("%s_off%0d", tag, i), {22'd0, qoff_a[i]}, i);
        end
    endtask

    initial begin
        int k, d0, f0, e0, bad, nlast;
        resetn = 1'b0; start_a = 1'b0; fod_a = 1'b0; start_b = 1'b0; fod_b = 1'b0;
        hang_a = 1'b0; bus_a.pix_ready = 1'b1; bus_b.pix_ready = 1'b1;
        repeat (3) step();
        chk_idle_a("reset");
        chk("reset_b_busy", {31'd0, busy_b}, 32'd0);
        resetn = 1'b1;
        step();

        // Basic frame with flip.
        qdata_a.delete(); qoff_a.delete(); d0 = dones_a; f0 = flips_a;
        pulse_start_a(1'b1);
        chk("basic_busy", {31'd0, busy_a}, 32'd1);
        wait_done_a("basic", 200);
        chk_frame_a("basic");
        chk("basic_ndone", dones_a - d0, 32'd1);
        chk("basic_flip", {31'd0, bus_a.flip_buffer}, 32'd1);
        chk("basic_nflips", flips_a - f0, 32'd1);
        chk("basic_busy_end", {31'd0, busy_a}, 32'd0);
        $display("txn basic: bytes=%0d done=%0d flip=%0d", qdata_a.size(), dones_a - d0, bus_a.flip_buffer);

        // Downstream stall on byte 2.
        qdata_a.delete(); qoff_a.delete();
        pulse_start_a(1'b1);
        for (k = 0; k < 200 && qoff_a.size() < 3; k++) step();
        bus_a.pix_ready = 1'b0;
        for (k = 0; k < 100 && !bus_a.pix_valid; k++) step();
        chk("stall_valid", {31'd0, bus_a.pix_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clock);
            chk($sformatf("stall_data_c%0d", i), {24'd0, bus_a.pix_data}, 32'hA2);
            chk($sformatf("stall_req_c%0d", i), {31'd0, bus_a.req_read_buffer}, 32'd0);
        end
        chk("stall_valid_held", {31'd0, bus_a.pix_valid}, 32'd1);
        step();
        bus_a.pix_ready = 1'b1;
        wait_done_a("stall", 200);
        chk_frame_a("stall");
        chk("stall_flip", {31'd0, bus_a.flip_buffer}, 32'd0);
        $display("txn stall: bytes=%0d flip=%0d", qdata_a.size(), bus_a.flip_buffer);

        // Controller never accepts: timeout abort.
        hang_a = 1'b1; d0 = dones_a; e0 = errs_a; f0 = flips_a;
        pulse_start_a(1'b1);
        for (k = 0; k < 20 && !bus_a.req_read_buffer; k++) step();
        for (k = 0; k < 20 && bus_a.req_read_buffer; k++) step();
        for (k = 0; k < 100 && !error_a; k++) step();
        chk("tmo_latency", k, 32'd32);
        chk("tmo_error", {31'd0, error_a}, 32'd1);
        chk("tmo_busy", {31'd0, busy_a}, 32'd0);
        step();
        chk("tmo_error_pulse", {31'd0, error_a}, 32'd0);
        repeat (2) step();
        chk("tmo_nerr", errs_a - e0, 32'd1);
        chk("tmo_ndone", dones_a - d0, 32'd0);
        chk("tmo_nflips", flips_a - f0, 32'd0);
        hang_a = 1'b0;
        $display("txn timeout: latency=%0d errors=%0d", k, errs_a - e0);

        // flip_on_done sampled only at start.
        qdata_a.delete(); qoff_a.delete(); d0 = dones_a; f0 = flips_a;
        pulse_start_a(1'b0);
        fod_a = 1'b1;
        wait_done_a("nofl", 200);
        chk("nofl_nbytes", qdata_a.size(), 32'd4);
        chk("nofl_nflips", flips_a - f0, 32'd0);
        chk("nofl_ndone", dones_a - d0, 32'd1);
        f0 = flips_a;
        pulse_start_a(1'b1);
        wait_done_a("fl2", 200);
        chk("fl2_nflips", flips_a - f0, 32'd1);
        chk("fl2_flip", {31'd0, bus_a.flip_buffer}, 32'd1);
        $display("txn fod: flips_second=%0d", flips_a - f0);

        // Extra start mid-frame, then reset at byte 2.
        qdata_a.delete(); qoff_a.delete(); d0 = dones_a;
        pulse_start_a(1'b1);
        for (k = 0; k < 200 && qoff_a.size() < 2; k++) step();
        pulse_start_a(1'b1);
        for (k = 0; k < 200 && qoff_a.size() < 3; k++) step();
        chk("rst_off2", {22'd0, qoff_a[2]}, 32'd2);
        chk("rst_nbytes_before", qdata_a.size(), 32'd2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk_idle_a("midrst");
        repeat (3) step();
        chk("midrst_ndone", dones_a - d0, 32'd0);
        qdata_a.delete(); qoff_a.delete();
        pulse_start_a(1'b1);
        wait_done_a("fresh", 200);
        chk_frame_a("fresh");
        $display("txn midreset: fresh_first_off=%0d bytes=%0d", qoff_a[0], qdata_a.size());

        // Full 256-byte frame.
        qdata_b.delete(); qoff_b.delete();
        fod_b = 1'b1; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (k = 0; k < 5000 && !done_b; k++) step();
        chk("full_done", {31'd0, done_b}, 32'd1);
        repeat (2) step();
        chk("full_nbytes", qdata_b.size(), 32'd256);
        chk("full_nreqs", qoff_b.size(), 32'd256);
        bad = 0; nlast = 0;
        for (int i = 0; i < qdata_b.size(); i++) begin
            if (qdata_b[i][7:0] !== 8'(8'hA0 + i)) bad++;
            if (qdata_b[i][8]) nlast++;
        end
        for (int i = 0; i < qoff_b.size(); i++) if (qoff_b[i] !== 10'(i)) bad++;
        chk("full_seq_errs", bad, 32'd0);
        chk("full_nlast", nlast, 32'd1);
        chk("full_last_flag", {31'd0, qdata_b[255][8]}, 32'd1);
        chk("full_last_off", {22'd0, qoff_b[255]}, 32'hFF);
        chk("full_flip", {31'd0, bus_b.flip_buffer}, 32'd1);
        $display("txn full: bytes=%0d last_off=0x%0h nlast=%0d", qdata_b.size(), qoff_b[255], nlast);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
